// File: rtl/aes_pkg.sv
// aes_pkg: shared AES tables, GF(2^8) helpers, legal key-size constants and FSM encoding.
package aes_pkg;
  localparam int AES128_N = 128, AES128_NR = 10, AES128_NK = 4;
  localparam int AES192_N = 192, AES192_NR = 12, AES192_NK = 6;
  localparam int AES256_N = 256, AES256_NR = 14, AES256_NK = 8;
  typedef enum logic [1:0] {IDLE, ROUND, HOLD} aes_fsm_e;
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rcon(input int i);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < i; j++) r = xtime(r);
    return r;
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
endpackage

// File: rtl/aes_enc_round.sv
// aes_enc_round: one combinational AES round; last skips MixColumns.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rkey,
  input  logic         last,
  output logic [127:0] next_state
);
  logic [7:0] sr [16];
  // byte i sits at row i%4, column i/4; ShiftRows folded into the S-box fetch
  always_comb begin
    for (int i = 0; i < 16; i++) sr[i] = sbox(state[127-8*((i+4*(i%4))%16) -: 8]);
    next_state = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        next_state[127-8*(4*c+r) -: 8] = rkey[127-8*(4*c+r) -: 8] ^ (last ? sr[4*c+r] :
          gmul(sr[4*c+r], 8'h02) ^ gmul(sr[4*c+(r+1)%4], 8'h03) ^ sr[4*c+(r+2)%4] ^ sr[4*c+(r+3)%4]);
  end
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: combinational FIPS-197 KeyExpansion, round key r at rks[128*r +: 128].
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic [32*Nk-1:0]       key,
  output logic [128*(Nr+1)-1:0]  rks
);
  localparam int NW = 4 * (Nr + 1);
  logic [31:0] w [NW];
  for (genvar i = 0; i < NW; i++) begin : g_w
    if (i < Nk) begin : g_key
      assign w[i] = key[32*(Nk-i)-1 -: 32];
    end else if (i % Nk == 0) begin : g_rot
      assign w[i] = w[i-Nk] ^ sub_word(rot_word(w[i-1])) ^ {rcon(i / Nk), 24'h0};
    end else if (Nk > 6 && i % Nk == 4) begin : g_sub
      assign w[i] = w[i-Nk] ^ sub_word(w[i-1]);
    end else begin : g_xor
      assign w[i] = w[i-Nk] ^ w[i-1];
    end
  end
  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign rks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end
endmodule

// File: rtl/aes_encrypt_seq.sv
// aes_encrypt_seq: iterative AES encryptor, one round per clock, valid/ready on both sides.
// Define AES_ENC_ZEROIZE_EN to clear the latched key and data on the output handshake.
module aes_encrypt_seq
  import aes_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  datain,
  input  logic [N-1:0]  key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  dataout,
  output logic          busy
);
  localparam logic [3:0] NR4 = 4'(Nr);
  aes_fsm_e fsm_q, fsm_d;
  logic [3:0] rnd_q, rnd_d;
  logic [N-1:0] key_q, key_d;
  logic [127:0] blk_q, blk_d, rnd_out, rk_sel;
  logic [128*(Nr+1)-1:0] rks;
  logic last;
  aes_key_expand #(.Nk(Nk), .Nr(Nr)) u_key_expand (.key(key_q), .rks(rks));
  assign last = rnd_q == NR4;
  assign rk_sel = rks[128*int'(rnd_q) +: 128];
  aes_enc_round u_round (.state(blk_q), .rkey(rk_sel), .last(last), .next_state(rnd_out));
  assign in_ready = fsm_q == IDLE;
  assign busy = fsm_q == ROUND;
  assign out_valid = fsm_q == HOLD;
  assign dataout = blk_q;
  // rk[0] is the leading key words, so whitening uses the input key directly
  always_comb begin
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    key_d = key_q;
    blk_d = blk_q;
    if (fsm_q == IDLE && in_valid) begin
      fsm_d = ROUND;
      rnd_d = 4'd1;
      key_d = key;
      blk_d = datain ^ key[N-1 -: 128];
    end else if (fsm_q == ROUND) begin
      fsm_d = last ? HOLD : ROUND;
      rnd_d = last ? rnd_q : rnd_q + 4'd1;
      blk_d = rnd_out;
    end else if (fsm_q == HOLD && out_ready) begin
      fsm_d = IDLE;
      rnd_d = '0;
`ifdef AES_ENC_ZEROIZE_EN
      key_d = '0;
      blk_d = '0;
`else
      key_d = key_q;
      blk_d = blk_q;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q <= IDLE;
      rnd_q <= '0;
      key_q <= '0;
      blk_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      key_q <= key_d;
      blk_q <= blk_d;
    end
  end
endmodule

// File: tb/tb_aes_encrypt_seq.sv
// tb_aes_encrypt_seq: AES-128 and AES-256 instances against a byte-matrix AES model and known answers.
module tb_aes_encrypt_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic in_valid [2], out_ready [2], in_ready [2], out_valid [2], busy [2], ovr_en [2];
  logic [127:0] datain [2], dataout [2], ovr_exp [2];
  logic [255:0] key [2];
  bit done = 1'b0;
  aes_encrypt_seq #(.N(128), .Nr(10), .Nk(4)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .datain(datain[0]), .key(key[0][127:0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .dataout(dataout[0]), .busy(busy[0]));
  aes_encrypt_seq #(.N(256), .Nr(14), .Nk(8)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .datain(datain[1]), .key(key[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .dataout(dataout[1]), .busy(busy[1]));
  logic [7:0] sb [256];
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction
  // S-box from its definition: multiplicative inverse followed by the affine map
  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  end
  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction
  function automatic logic [127:0] aes_ref(input logic [255:0] k, input int nk, input logic [127:0] pt);
    logic [31:0] w [60];
    logic [7:0] s [16], t [16];
    logic [31:0] tmp;
    logic [7:0] rc;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = k[32*(nk-i)-1 -: 32];
      else begin
        tmp = w[i-1];
        if (i % nk == 0) begin
          tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) tmp = subw(tmp);
        w[i] = w[i-nk] ^ tmp;
      end
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row+4*c] = sb[s[row+4*((c+row)%4)]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[4*c+row] = w[4*r+c][31-8*row -: 8] ^ ((r == nr) ? t[4*c+row] :
            gm(t[4*c+row], 8'h02) ^ gm(t[4*c+(row+1)%4], 8'h03) ^ t[4*c+(row+2)%4] ^ t[4*c+(row+3)%4]);
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input int i, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, i, act, exp);
    end
  endtask
  logic [127:0] sbq [2][$];
  bit active [2], acc_p [2], hs_p [2];
  bit rst_p [2] = '{1'b1, 1'b1};
  int cnt [2];
  int nr_of [2] = '{10, 14};
  int nk_of [2] = '{4, 8};
  // monitor: advance the transaction-level model by the edge just taken, then compare
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_p[i]) begin
        active[i] = 1'b0;
        cnt[i] = 0;
        sbq[i].delete();
      end else if (acc_p[i]) begin
        active[i] = 1'b1;
        cnt[i] = 0;
      end else if (hs_p[i]) begin
        active[i] = 1'b0;
        void'(sbq[i].pop_front());
      end else if (active[i] && cnt[i] < nr_of[i]) cnt[i]++;
      chk("in_ready", i, in_ready[i], !active[i]);
      chk("busy", i, busy[i], active[i] && cnt[i] < nr_of[i]);
      chk("out_valid", i, out_valid[i], active[i] && cnt[i] == nr_of[i]);
      if (rst_p[i]) chk("reset_dataout", i, dataout[i], 128'h0);
      if (active[i] && cnt[i] == nr_of[i]) begin
        if (sbq[i].size() == 0) chk("unexpected_output", i, 128'h1, 128'h0);
        else chk("dataout", i, dataout[i], sbq[i][0]);
      end
      rst_p[i] = !reset;
      acc_p[i] = reset && in_valid[i] && !active[i];
      hs_p[i] = reset && active[i] && cnt[i] == nr_of[i] && out_ready[i];
      if (acc_p[i]) sbq[i].push_back(ovr_en[i] ? ovr_exp[i] : aes_ref(key[i], nk_of[i], datain[i]));
    end
    if (done) begin
      for (int i = 0; i < 2; i++) chk("drain", i, 128'(sbq[i].size()), 128'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end
  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rand_inputs();
    for (int i = 0; i < 2; i++) begin
      datain[i] = rnd128();
      key[i] = {rnd128(), rnd128()};
    end
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b1;
      datain[i] = '0;
      key[i] = '0;
      ovr_en[i] = 1'b0;
      ovr_exp[i] = '0;
    end
    cyc(3);
    reset = 1'b1;
    key[0] = 256'h000102030405060708090a0b0c0d0e0f;
    datain[0] = 128'h00112233445566778899aabbccddeeff;
    ovr_exp[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    key[1] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    datain[1] = 128'h00112233445566778899aabbccddeeff;
    ovr_exp[1] = 128'h8ea2b7ca516745bfeafc49904b496089;
    for (int i = 0; i < 2; i++) begin
      ovr_en[i] = 1'b1;
      in_valid[i] = 1'b1;
    end
    cyc(1);
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
    ovr_en[1] = 1'b0;
    cyc(20);
    key[0] = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    datain[0] = 128'h3243f6a8885a308d313198a2e0370734;
    ovr_exp[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    cyc(1);
    ovr_en[0] = 1'b0;
    repeat (30) begin
      in_valid[0] = 1'($urandom_range(0, 1));
      rand_inputs();
      cyc(1);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    cyc(3);
    rand_inputs();
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b1;
    cyc(1);
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
    cyc(4);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b1;
    cyc(1);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
    cyc(3);
    rand_inputs();
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b1;
    cyc(1);
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
    cyc(16);
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b1;
    repeat (36) begin
      rand_inputs();
      cyc(1);
    end
    for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
    cyc(16);
    repeat (400) begin
      rand_inputs();
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = 1'($urandom_range(0, 1));
        out_ready[i] = ($urandom_range(0, 3) != 0);
      end
      reset = ($urandom_range(0, 99) != 0);
      cyc(1);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b1;
    end
    cyc(20);
    done = 1'b1;
  end
endmodule

// File: doc/aes_encrypt_seq.md
AES_ENCRYPT_SEQ -- requirements
Module: aes_encrypt_seq

Interface
REQ-001 Parameter N, default 128: key width in bits; legal values are 128, 192 and 256.
REQ-002 Parameter Nr, default 10: number of rounds; legal values are 10, 12 and 14, paired with N.
REQ-003 Parameter Nk, default 4: key words; legal values are 4, 6 and 8, paired with N.
REQ-004 Port clk, input, 1 bit: the single clock; every register SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port in_valid, input, 1 bit: datain and key are valid.
REQ-007 Port in_ready, output, 1 bit: the block can accept a new block.
REQ-008 Port datain, input, 128 bits: plaintext, in FIPS-197 byte order with byte 0 at [127:120].
REQ-009 Port key, input, N bits: cipher key.
REQ-010 Port out_valid, output, 1 bit: ciphertext on dataout is valid.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts dataout.
REQ-012 Port dataout, output, 128 bits: ciphertext.
REQ-013 Port busy, output, 1 bit: high while in the ROUND state.

Function
REQ-014 The FSM SHALL have the states IDLE, ROUND and HOLD; IDLE is the reset state.
REQ-015 in_ready SHALL equal (state==IDLE).
REQ-016 A transfer occurs on the edge where in_valid and in_ready are both 1: key is latched, state_reg <= datain ^ rk[0], rnd <= 1, and the FSM goes to ROUND.
REQ-017 In ROUND, each edge SHALL apply SubBytes, ShiftRows, MixColumns and AddRoundKey(rk[rnd]) to state_reg and then increment rnd.
REQ-018 When rnd==Nr, the round SHALL omit MixColumns; on that edge the FSM goes to HOLD and out_valid <= 1.
REQ-019 Latency: out_valid SHALL rise exactly Nr edges after the accepting edge (10, 12 or 14 edges).
REQ-020 In HOLD, dataout and out_valid SHALL stay stable until out_ready==1.
REQ-021 On the edge where out_valid and out_ready are both 1, out_valid <= 0 and the FSM returns to IDLE.
REQ-022 No new block is accepted on that same edge; the next accept is possible one edge later.
REQ-023 in_valid in ROUND or HOLD SHALL be ignored, and no input data is captured.
REQ-024 out_ready outside HOLD SHALL have no effect.
REQ-025 Round keys SHALL come from the latched key only, so changes on the key input mid-operation have no effect.
REQ-026 rnd SHALL be 4 bits wide and never exceed Nr.
REQ-027 dataout SHALL be driven directly from state_reg.

Reset
REQ-028 While reset==0 at an edge: state <= IDLE, in_ready=1 afterwards, out_valid=0, busy=0, rnd=0, and dataout=0 (state_reg=0).
REQ-029 A reset in ROUND or HOLD SHALL abort the operation, with no out_valid pulse and the result discarded.
REQ-030 Reset SHALL take priority over every handshake on the same edge.

Configuration
REQ-031 When the macro AES_ENC_ZEROIZE_EN is defined, the latched key and state_reg SHALL be cleared to 0 on the output-handshake edge, so dataout reads 0 in IDLE.
REQ-032 Without AES_ENC_ZEROIZE_EN, the latched key and state_reg SHALL retain their last values until the next accept or reset.

Structure
REQ-033 Package aes_pkg SHALL hold the forward S-box table, the xtime/GF(2^8) multiply functions, and the constants for the legal (N, Nr, Nk) triplets.
REQ-034 Sub-module aes_enc_round SHALL be combinational, with inputs state, round key and a last flag, and output next state; the last flag bypasses MixColumns.
REQ-035 The existing KeyExpansion block SHALL be reused on the latched key to produce rk[0..Nr].

Verification
REQ-036 AES-128 test: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> dataout 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 10 edges after accept.
REQ-037 AES-128 test: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-038 AES-256 test (N=256, Nr=14, Nk=8): key 000102...1e1f, pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089, with out_valid 14 edges after accept.
REQ-039 Backpressure test: hold out_ready=0 for 20 cycles and toggle key/datain/in_valid meanwhile -> dataout stable, in_ready=0, and the result unchanged when released.
REQ-040 Reset test: reset=0 at round 5, then release -> out_valid never rises, all outputs match REQ-028, and a following vector encrypts correctly.
REQ-041 Back-to-back test: in_valid held high with two vectors -> second accept one edge after the first output handshake, and both results correct.
